// File: rtl/qu_common.sv
// Shared rename-stage types and constants for the physical-register free list.
package qu_common;

    localparam int unsigned PHY_RF_DEPTH_DEF = 128;
    localparam int unsigned NUM_ALLOC_PORTS  = 3;
    localparam int unsigned NUM_REL_PORTS    = 2;

    typedef logic [$clog2(PHY_RF_DEPTH_DEF)-1:0] phy_tag_t;

    typedef enum logic [0:0] {
        FL_INIT,
        FL_RUN
    } fl_state_t;

endpackage

// File: rtl/free_list_ram.sv
// Circular-FIFO storage for free tags: combinational reads, synchronous pushes and init fill.
module free_list_ram #(
    parameter int unsigned ENTRIES  = 127,
    parameter int unsigned AW       = 7,
    parameter int unsigned DW       = 7,
    parameter int unsigned RD_PORTS = 3,
    parameter int unsigned WR_PORTS = 2
) (
    input  logic                              clk,
    input  logic [RD_PORTS-1:0][AW-1:0]       rd_addr,
    output logic [RD_PORTS-1:0][DW-1:0]       rd_data,
    input  logic [WR_PORTS-1:0]               wr_en,
    input  logic [WR_PORTS-1:0][AW-1:0]       wr_addr,
    input  logic [WR_PORTS-1:0][DW-1:0]       wr_data,
    input  logic                              init_we,
    input  logic [AW-1:0]                     init_addr,
    input  logic [DW-1:0]                     init_data
);

    logic [DW-1:0] mem [ENTRIES];

    always_comb begin
        for (int i = 0; i < int'(RD_PORTS); i++) begin
            rd_data[i] = mem[rd_addr[i]];
        end
    end

    // Init and release writes never coincide: init only runs while releases are ignored.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end
        for (int j = 0; j < int'(WR_PORTS); j++) begin
            if (wr_en[j]) begin
                mem[wr_addr[j]] <= wr_data[j];
            end
        end
    end

endmodule

// File: rtl/phyreg_free_list.sv
// Physical-register tag allocator: circular FIFO of free tags with self-sequenced init.
module phyreg_free_list
    import qu_common::*;
#(
    parameter int unsigned PHY_RF_DEPTH = PHY_RF_DEPTH_DEF,
    parameter int unsigned ALLOC_PORTS  = NUM_ALLOC_PORTS,
    parameter int unsigned REL_PORTS    = NUM_REL_PORTS,
    localparam int unsigned TW          = $clog2(PHY_RF_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [ALLOC_PORTS-1:0]           alloc_req,
    output logic                             alloc_gnt,
    output logic [ALLOC_PORTS-1:0][TW-1:0]   alloc_tag,
    input  logic [REL_PORTS-1:0]             rel_valid,
    input  logic [REL_PORTS-1:0][TW-1:0]     rel_tag,
    output logic [TW-1:0]                    num_free,
    output logic                             low,
    output logic                             ready,
    output logic                             overflow_err
);

    localparam int unsigned CAP = PHY_RF_DEPTH - 1;
    localparam logic [TW-1:0] CAP_T = TW'(CAP);
    localparam logic [TW:0] CAP_W = (TW+1)'(CAP);
    localparam int unsigned OW = (ALLOC_PORTS > 1) ? $clog2(ALLOC_PORTS) : 1;

    fl_state_t     state_q, state_d;
    logic [TW-1:0] init_cnt_q, init_cnt_d;
    logic [TW-1:0] head_q, head_d;
    logic [TW-1:0] tail_q, tail_d;
    logic [TW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [TW-1:0]                   n;
    logic [TW-1:0]                   cnt_rel;
    logic [TW-1:0]                   tail_rel;
    logic [OW-1:0]                   off;
    logic [ALLOC_PORTS-1:0][TW-1:0]  rd_addr;
    logic [ALLOC_PORTS-1:0][TW-1:0]  rd_data;
    logic [REL_PORTS-1:0]            wr_en;
    logic [REL_PORTS-1:0][TW-1:0]    wr_addr;
    logic                            init_we;
    logic [TW-1:0]                   init_addr;

    // CAP is not a power of two, so wrap by compare-and-subtract.
    function automatic logic [TW-1:0] ptr_add(input logic [TW-1:0] p, input logic [TW-1:0] inc);
        logic [TW:0] s;
        s = {1'b0, p} + {1'b0, inc};
        if (s >= CAP_W) begin
            s = s - CAP_W;
        end
        return s[TW-1:0];
    endfunction

    assign ready        = (state_q == FL_RUN);
    assign low          = !ready || (count_q < TW'(3));
    assign num_free     = count_q;
    assign overflow_err = ovf_q;

    always_comb begin
        n = '0;
        for (int i = 0; i < int'(ALLOC_PORTS); i++) begin
            n = n + TW'(alloc_req[i]);
            rd_addr[i] = ptr_add(head_q, TW'(i));
        end
        alloc_gnt = ready && !flush && (n != '0) && (n <= count_q);

        // Each requested slot takes the next FIFO entry in ascending slot order.
        off = '0;
        for (int k = 0; k < int'(ALLOC_PORTS); k++) begin
            alloc_tag[k] = '0;
            if (alloc_gnt && alloc_req[k]) begin
                alloc_tag[k] = rd_data[off];
            end
            off = off + OW'(alloc_req[k]);
        end

        // Releases see the count after this cycle's pops and earlier pushes.
        cnt_rel  = count_q - (alloc_gnt ? n : '0);
        tail_rel = tail_q;
        ovf_d    = ovf_q;
        for (int j = 0; j < int'(REL_PORTS); j++) begin
            wr_en[j]   = 1'b0;
            wr_addr[j] = tail_rel;
            if (ready && !flush && rel_valid[j] && (rel_tag[j] != '0)) begin
                if (cnt_rel < CAP_T) begin
                    wr_en[j] = 1'b1;
                    cnt_rel  = cnt_rel + TW'(1);
                    tail_rel = ptr_add(tail_rel, TW'(1));
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        init_we    = 1'b0;
        init_addr  = init_cnt_q - TW'(1);
        case (state_q)
            FL_INIT: begin
                if (flush) begin
                    init_cnt_d = TW'(1);
                end else begin
                    init_we = 1'b1;
                    if (init_cnt_q == CAP_T) begin
                        state_d    = FL_RUN;
                        init_cnt_d = TW'(1);
                        head_d     = '0;
                        tail_d     = '0;
                        count_d    = CAP_T;
                    end else begin
                        init_cnt_d = init_cnt_q + TW'(1);
                    end
                end
            end
            FL_RUN: begin
                if (flush) begin
                    state_d    = FL_INIT;
                    init_cnt_d = TW'(1);
                    head_d     = '0;
                    tail_d     = '0;
                    count_d    = '0;
                end else begin
                    head_d  = alloc_gnt ? ptr_add(head_q, n) : head_q;
                    tail_d  = tail_rel;
                    count_d = cnt_rel;
                end
            end
            default: state_d = FL_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FL_INIT;
            init_cnt_q <= TW'(1);
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    free_list_ram #(
        .ENTRIES  (CAP),
        .AW       (TW),
        .DW       (TW),
        .RD_PORTS (ALLOC_PORTS),
        .WR_PORTS (REL_PORTS)
    ) u_ram (
        .clk       (clk),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (rel_tag),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_cnt_q)
    );

endmodule

// File: tb/tb_phyreg_free_list.sv
// Randomised bench for phyreg_free_list against a queue-based model of the free tag pool.
module tb_phyreg_free_list;

    localparam int CAP = 127;
    localparam int TW  = 7;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [2:0]           alloc_req;
    logic                 alloc_gnt;
    logic [2:0][TW-1:0]   alloc_tag;
    logic [1:0]           rel_valid;
    logic [1:0][TW-1:0]   rel_tag;
    logic [TW-1:0]        num_free;
    logic                 low;
    logic                 ready;
    logic                 overflow_err;

    int n_cmp;
    int n_bad;

    // Model: free pool as an ordered queue, plus tags currently handed out.
    int m_q[$];
    int outst[$];
    bit m_ready;
    int m_init_left;
    bit m_ovf;
    bit exp_gnt;
    int exp_tag[3];
    int obs_gnt;
    int obs_tag[3];

    phyreg_free_list u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_tag    (alloc_tag),
        .rel_valid    (rel_valid),
        .rel_tag      (rel_tag),
        .num_free     (num_free),
        .low          (low),
        .ready        (ready),
        .overflow_err (overflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before 1000000");
        $fatal(1, "bench timeout");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        outst.delete();
        m_ready     = 1'b0;
        m_init_left = CAP;
        m_ovf       = 1'b0;
        exp_gnt     = 1'b0;
        for (int s = 0; s < 3; s++) exp_tag[s] = 0;
    endtask

    task automatic check_outputs();
        check_val("ready", int'(ready), int'(m_ready));
        check_val("num_free", int'(num_free), m_q.size());
        check_val("low", int'(low), int'(!m_ready || m_q.size() < 3));
        check_val("alloc_gnt", int'(alloc_gnt), int'(exp_gnt));
        for (int s = 0; s < 3; s++) check_val($sformatf("alloc_tag%0d", s),
                                              int'(alloc_tag[s]), exp_tag[s]);
        check_val("overflow_err", int'(overflow_err), int'(m_ovf));
    endtask

    // One clock: drive at edge+1, check mid-cycle, advance the model at the edge.
    task automatic cyc(input logic [2:0] req, input logic [1:0] rv, input int t0, input int t1,
                       input bit fl);
        int n;
        int k;
        alloc_req  = req;
        rel_valid  = rv;
        rel_tag[0] = TW'(t0);
        rel_tag[1] = TW'(t1);
        flush      = fl;
        n = $countones(req);
        exp_gnt = m_ready && !fl && n > 0 && n <= m_q.size();
        k = 0;
        for (int s = 0; s < 3; s++) begin
            exp_tag[s] = 0;
            if (exp_gnt && req[s]) begin
                exp_tag[s] = m_q[k];
                k++;
            end
        end
        #4;
        check_outputs();
        obs_gnt = int'(alloc_gnt);
        for (int s = 0; s < 3; s++) obs_tag[s] = int'(alloc_tag[s]);
        @(posedge clk);
        if (!m_ready) begin
            if (fl) begin
                m_init_left = CAP;
            end else begin
                m_init_left--;
                if (m_init_left == 0) begin
                    m_ready = 1'b1;
                    for (int t = 1; t <= CAP; t++) m_q.push_back(t);
                end
            end
        end else if (fl) begin
            m_ready     = 1'b0;
            m_init_left = CAP;
            m_q.delete();
            outst.delete();
        end else begin
            if (exp_gnt) for (int s = 0; s < 3; s++) if (req[s]) outst.push_back(m_q.pop_front());
            for (int s = 0; s < 2; s++) begin
                if (rv[s] && (s == 0 ? t0 : t1) != 0) begin
                    if (m_q.size() < CAP) m_q.push_back(s == 0 ? t0 : t1);
                    else m_ovf = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic pick(output int t);
        int i;
        if (outst.size() == 0) begin
            t = 0;
        end else begin
            i = $urandom_range(0, outst.size() - 1);
            t = outst[i];
            outst.delete(i);
        end
    endtask

    task automatic take(input int t);
        for (int i = 0; i < outst.size(); i++) begin
            if (outst[i] == t) begin
                outst.delete(i);
                return;
            end
        end
    endtask

    task automatic rand_cycle();
        int r;
        int t[2];
        logic [1:0] rv;
        rv = 2'b00;
        for (int j = 0; j < 2; j++) begin
            t[j] = 0;
            r = $urandom_range(0, 19);
            if (r < 8) begin
                pick(t[j]);
                rv[j] = 1'b1;
            end else if (r == 8) begin
                rv[j] = 1'b1;
            end else if (r == 9) begin
                t[j]  = $urandom_range(1, CAP);
                rv[j] = 1'b1;
            end
        end
        cyc(3'($urandom_range(0, 7)), rv, t[0], t[1], 1'b0);
    endtask

    initial begin
        int t0;
        int t1;
        int r;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        flush = 1'b0;
        alloc_req = '0;
        rel_valid = '0;
        rel_tag = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;

        repeat (CAP) cyc(3'b000, 2'b00, 0, 0, 1'b0);
        check_val("ready_after_init", int'(ready), 1);
        check_val("free_after_init", int'(num_free), 127);
        cyc(3'b111, 2'b00, 0, 0, 1'b0);
        check_val("first_tag0", obs_tag[0], 1);
        check_val("first_tag1", obs_tag[1], 2);
        check_val("first_tag2", obs_tag[2], 3);
        check_val("free_after_first", int'(num_free), 124);
        cyc(3'b101, 2'b00, 0, 0, 1'b0);
        check_val("sparse_tag0", obs_tag[0], 4);
        check_val("sparse_tag1", obs_tag[1], 0);
        check_val("sparse_tag2", obs_tag[2], 5);
        check_val("free_after_sparse", int'(num_free), 122);

        // Drain to 2, refuse a triple, then grant a single.
        while (m_q.size() >= 3) cyc(3'b111, 2'b00, 0, 0, 1'b0);
        while (m_q.size() > 2) cyc(3'b001, 2'b00, 0, 0, 1'b0);
        cyc(3'b111, 2'b00, 0, 0, 1'b0);
        check_val("no_partial_gnt", obs_gnt, 0);
        check_val("free_held_at_2", int'(num_free), 2);
        cyc(3'b001, 2'b00, 0, 0, 1'b0);
        check_val("single_gnt", obs_gnt, 1);
        take(1);
        take(2);
        cyc(3'b000, 2'b11, 1, 2, 1'b0);
        take(7);
        take(9);
        cyc(3'b111, 2'b11, 7, 9, 1'b0);
        check_val("gnt_with_release", obs_gnt, 1);
        check_val("free_after_swap", int'(num_free), 2);
        cyc(3'b001, 2'b00, 0, 0, 1'b0);
        check_val("returned_first", obs_tag[0], 7);
        cyc(3'b001, 2'b00, 0, 0, 1'b0);
        check_val("returned_second", obs_tag[0], 9);

        // Return every tag in scrambled order, with tag-0 strobes mixed in.
        while (outst.size() > 0) begin
            r = $urandom_range(0, 3);
            case (r)
                0: begin pick(t0); cyc(3'b000, 2'b11, t0, 0, 1'b0); end
                1: begin
                    pick(t0);
                    pick(t1);
                    cyc(3'b000, (t1 != 0) ? 2'b11 : 2'b01, t0, t1, 1'b0);
                end
                2: begin pick(t1); cyc(3'b000, 2'b10, 0, t1, 1'b0); end
                default: cyc(3'b000, 2'b00, 0, 0, 1'b0);
            endcase
        end
        check_val("free_full", int'(num_free), 127);
        cyc(3'b000, 2'b01, 5, 0, 1'b0);
        check_val("overflow_set", int'(overflow_err), 1);
        check_val("free_after_ovf", int'(num_free), 127);
        while (m_q.size() > 0) begin
            cyc((m_q.size() >= 3) ? 3'($urandom_range(1, 7)) : 3'b001, 2'b00, 0, 0, 1'b0);
        end

        repeat (1500) rand_cycle();

        // Flush in RUN beats a simultaneous triple request; overflow stays sticky.
        cyc(3'b111, 2'b00, 0, 0, 1'b1);
        check_val("flush_no_gnt", obs_gnt, 0);
        repeat (CAP) cyc(3'b000, 2'b00, 0, 0, 1'b0);
        cyc(3'b111, 2'b00, 0, 0, 1'b0);
        check_val("post_flush_tag0", obs_tag[0], 1);
        check_val("post_flush_tag1", obs_tag[1], 2);
        check_val("post_flush_tag2", obs_tag[2], 3);
        repeat (50) rand_cycle();

        // Flush, restart init with a second flush, then reset asynchronously mid-INIT.
        cyc(3'b000, 2'b00, 0, 0, 1'b1);
        repeat (20) cyc(3'b000, 2'b00, 0, 0, 1'b0);
        cyc(3'b000, 2'b00, 0, 0, 1'b1);
        repeat (40) cyc(3'b000, 2'b00, 0, 0, 1'b0);
        alloc_req = '0;
        rel_valid = '0;
        flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (CAP) cyc(3'b000, 2'b00, 0, 0, 1'b0);
        repeat (60) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phyreg_free_list.md
Name: phyreg_free_list

Overview:
- Allocator for physical-register tags. It shares the physical register file between two users: the map stage, which allocates up to 3 tags per cycle, and commit, which releases up to 2 tags per cycle.
- It replaces ad-hoc scanning of a renamed-bit vector with a circular FIFO of free tags.
- It sequences its own initialisation after reset or flush, and reports availability so the map stage can stall.
- Tag 0 is reserved to mean "unmapped" and is never stored or handed out.

Parameters:
- PHY_RF_DEPTH, 128, number of physical registers. Capacity CAP = PHY_RF_DEPTH-1 (tags 1..CAP).
- ALLOC_PORTS, 3, allocation slots. Slot 0 = rd, slot 1 = rs1, slot 2 = rs2. Fixed at 3.
- REL_PORTS, 2, release slots. Fixed at 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; re-initialise the free list (all tags free).
- alloc_req  in  3  per-slot allocation request.
- alloc_gnt  out  1  all requested slots granted this cycle.
- alloc_tag  out  3 x clog2(PHY_RF_DEPTH)  tag per slot; 0 for unrequested slots or when not granted.
- rel_valid  in  2  per-slot release strobe.
- rel_tag  in  2 x clog2(PHY_RF_DEPTH)  tags being released.
- num_free  out  clog2(PHY_RF_DEPTH)  current free count.
- low  out  1  fewer than 3 tags free, or not ready; drives the map-stage stall.
- ready  out  1  initialisation complete.
- overflow_err  out  1  sticky: a release was attempted with the list full.

Behaviour:
- State machine: INIT and RUN.
- Reset (rst=0, asynchronous), applies immediately:
  - state=INIT, init_cnt=1, head=0, tail=0, count=0, overflow_err=0.
  - Outputs: ready=0, alloc_gnt=0, alloc_tag all 0, low=1, num_free=0.
- INIT:
  - Each cycle writes tag init_cnt into mem[init_cnt-1] and increments init_cnt.
  - When init_cnt==CAP is written, the next state is RUN with head=0, tail=0, count=CAP.
  - INIT therefore lasts CAP cycles (127 by default).
  - alloc_req and rel_valid are ignored; no grant is given.
- RUN, allocation:
  - n = popcount(alloc_req).
  - Requested slots take consecutive FIFO entries mem[head], mem[head+1], ... in ascending slot order.
  - alloc_gnt = (n>0) && (n<=count). The decision uses the registered count; tags released in the same cycle are not bypassed.
  - alloc_tag is combinational from alloc_req and head, and is valid in the same cycle as alloc_gnt.
  - If n>count: alloc_gnt=0, all alloc_tag=0, and head/count are unchanged. Partial grants are not allowed.
  - On grant: head advances by n, modulo CAP.
- RUN, release:
  - Each valid slot with a nonzero tag is pushed at tail, slot 0 first.
  - rel_tag==0 is ignored silently.
  - A push that would make count exceed CAP is dropped and sets overflow_err (sticky until reset).
  - Overflow is evaluated per slot against the count after pops and earlier pushes in the same cycle.
  - tail advances by the number of accepted pushes, modulo CAP.
- Count update: count_next = count - (alloc_gnt ? n : 0) + accepted_pushes.
- Pointer wrap: CAP is not a power of two. Pointer arithmetic uses explicit compare-and-subtract, never a bit-width wrap.
- Status outputs:
  - low = !ready || count<3.
  - num_free = count.
  - ready = (state==RUN).
- Flush:
  - In RUN, flush has priority over allocation and release that cycle: no grant, releases dropped.
  - Next state is INIT with init_cnt=1, count=0, head=0, tail=0.
  - Flush during INIT restarts init_cnt at 1.
  - overflow_err is not cleared by flush.
- No duplicate-tag detection. Commit guarantees it never releases a live tag.

Decomposition:
- Shared package qu_common:
  - phy_tag_t (logic [clog2(PHY_RF_DEPTH)-1:0]).
  - fl_state_t enum {FL_INIT, FL_RUN}.
  - Constants NUM_ALLOC_PORTS=3, NUM_REL_PORTS=2.
- Sub-module free_list_ram: CAP x tag storage with 3 combinational read ports and 2 synchronous write ports plus an init write port. Pointers, counting and the FSM stay in phyreg_free_list.

Test Plan:
- Release reset, no requests -> ready=0 and low=1 for 127 cycles, then ready=1, num_free=127; alloc_req=3'b111 -> alloc_gnt=1, tags {1,2,3}; next cycle num_free=124.
- After the above, alloc_req=3'b101 -> alloc_tag[0]=4, alloc_tag[1]=0, alloc_tag[2]=5; num_free=122.
- Drain to count=2, alloc_req=3'b111 -> alloc_gnt=0, all tags 0, count stays 2, low=1; alloc_req=3'b001 -> granted.
- count=3, alloc_req=3'b111 with rel_valid=2'b11, rel_tag={9,7} -> granted; next count=2; tags 7 then 9 are returned later in that order.
- Allocate all 127 then release 127 in scrambled order across the wrap -> re-allocation returns tags in release order; head/tail wrap at 127 with no lost or duplicated tags. rel_tag=0 changes nothing. A release at count=127 sets overflow_err=1.
- Flush in RUN with a simultaneous alloc_req=3'b111 -> no grant; ready=0 for 127 cycles; after init the first allocation returns {1,2,3}. rst low mid-INIT -> outputs return to reset values immediately.
